// File: rtl/rec_play_sequencer.sv
// Record/playback sequencer: turns user events into an FSM and issues one SRAM
// write (record) or read (play) request per audio sample tick over a req/ready handshake.
module rec_play_sequencer #(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_event_valid,
    input  logic [3:0]        i_event_code,
    input  logic [1:0]        i_mode,
    input  logic [3:0]        i_speed,
    input  logic              i_sample_tick,
    input  logic              i_mem_ready,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [2:0]        o_state,
    output logic [ADDR_W:0]   o_rec_len,
    output logic [2:0]        o_interp_phase,
    output logic              o_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REC   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_STOP  = 3'd3,
        ST_PLAY  = 3'd4
    } state_t;

    localparam logic [3:0] EV_REC   = 4'd1;
    localparam logic [3:0] EV_PAUSE = 4'd2;
    localparam logic [3:0] EV_STOP  = 4'd3;
    localparam logic [3:0] EV_PLAY  = 4'd4;

    function automatic logic [3:0] eff_speed(input logic [1:0] mode, input logic [3:0] spd);
        if ((mode == 2'b01 || mode == 2'b10) && spd >= 4'd2 && spd <= 4'd8)
            return spd;
        return 4'd1;
    endfunction

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rec_addr;
    logic [ADDR_W-1:0] play_addr;
    logic [ADDR_W:0]   rec_len;
    logic [2:0]        phase;
    logic [1:0]        mode_r;
    logic [3:0]        speed_r;
    logic              from_play, from_nxt;
    logic              vld_p0;
    logic [3:0]        evt_code_p0;

    logic              acc;
    logic              evt_go;
    logic [3:0]        evt_code;
    logic              tick_slot;
    logic [3:0]        s_eff;
    logic              slow_active;
    logic              phase_last;
    logic [ADDR_W:0]   play_sum;
    logic [ADDR_W:0]   slow_sum;
    logic              fresh_rec, play_zero, enter_stop;
    logic              issue, issue_we;

    assign acc         = o_mem_req & i_mem_ready;
    assign s_eff       = eff_speed(mode_r, speed_r);
    assign slow_active = (mode_r == 2'b01) && (s_eff != 4'd1);
    assign phase_last  = (phase == 3'(s_eff - 4'd1));
    assign play_sum    = {1'b0, play_addr} + (ADDR_W+1)'(s_eff);
    assign slow_sum    = {1'b0, play_addr} + (ADDR_W+1)'(1);

    // Events are held off while a request is outstanding; a live event beats a latched one.
    always_comb begin
        evt_go   = 1'b0;
        evt_code = 4'd0;
        if (!o_mem_req) begin
            if (i_event_valid) begin
                evt_go   = 1'b1;
                evt_code = i_event_code;
            end else if (vld_p0) begin
                evt_go   = 1'b1;
                evt_code = evt_code_p0;
            end
        end
    end

    // A tick coinciding with an applied event is not serviced.
    assign tick_slot = i_sample_tick & ~o_mem_req & ~evt_go;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        fresh_rec  = 1'b0;
        play_zero  = 1'b0;
        enter_stop = 1'b0;
        from_nxt   = from_play;
        if (acc) begin
            if (state == ST_REC && o_mem_we && rec_addr == MAX_ADDR)
                enter_stop = 1'b1;
            else if (state == ST_PLAY && !o_mem_we && !slow_active && play_sum >= rec_len)
                enter_stop = 1'b1;
        end else if (evt_go) begin
            case (state)
                ST_IDLE: begin
                    if (evt_code == EV_REC) begin
                        state_nxt = ST_REC;
                        fresh_rec = 1'b1;
                    end
                end
                ST_REC: begin
                    if (evt_code == EV_PAUSE) begin
                        state_nxt = ST_PAUSE;
                        from_nxt  = 1'b0;
                    end else if (evt_code == EV_STOP) begin
                        enter_stop = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (evt_code == EV_PAUSE) begin
                        state_nxt = ST_PAUSE;
                        from_nxt  = 1'b1;
                    end else if (evt_code == EV_STOP) begin
                        enter_stop = 1'b1;
                    end else if (evt_code == EV_REC) begin
                        state_nxt = ST_REC;
                        fresh_rec = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (evt_code == EV_REC) begin
                        state_nxt = ST_REC;
                        fresh_rec = from_play;
                    end else if (evt_code == EV_PLAY) begin
                        state_nxt = ST_PLAY;
                        play_zero = ~from_play;
                    end else if (evt_code == EV_STOP) begin
                        enter_stop = 1'b1;
                    end
                end
                ST_STOP: begin
                    if (evt_code == EV_REC) begin
                        state_nxt = ST_REC;
                        fresh_rec = 1'b1;
                    end else if (evt_code == EV_PLAY && rec_len != '0) begin
                        state_nxt = ST_PLAY;
                        play_zero = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (tick_slot && state == ST_PLAY && slow_active && phase_last
                     && slow_sum >= rec_len) begin
            enter_stop = 1'b1;
        end
        if (enter_stop)
            state_nxt = ST_STOP;
    end

    always_comb begin
        o_state  = state;
        issue    = 1'b0;
        issue_we = 1'b0;
        if (tick_slot) begin
            if (state == ST_REC) begin
                issue    = 1'b1;
                issue_we = 1'b1;
            end else if (state == ST_PLAY) begin
                issue = !slow_active || (phase == 3'd0);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rec_addr    <= '0;
            play_addr   <= '0;
            rec_len     <= '0;
            phase       <= '0;
            mode_r      <= '0;
            speed_r     <= '0;
            from_play   <= 1'b0;
            vld_p0      <= 1'b0;
            evt_code_p0 <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_overrun   <= 1'b0;
        end else begin
            o_overrun <= i_sample_tick & o_mem_req;
            from_play <= from_nxt;
            if (i_event_valid) begin
                mode_r  <= i_mode;
                speed_r <= i_speed;
            end
            if (o_mem_req) begin
                if (i_event_valid) begin
                    vld_p0      <= 1'b1;
                    evt_code_p0 <= i_event_code;
                end
            end else begin
                vld_p0 <= 1'b0;
            end

            if (acc) begin
                o_mem_req <= 1'b0;
                o_mem_we  <= 1'b0;
                if (o_mem_we) begin
                    rec_addr <= rec_addr + ADDR_W'(1);
                    rec_len  <= {1'b0, rec_addr} + (ADDR_W+1)'(1);
                end else if (!slow_active) begin
                    play_addr <= play_sum[ADDR_W-1:0];
                    phase     <= '0;
                end
            end else if (issue) begin
                o_mem_req  <= 1'b1;
                o_mem_we   <= issue_we;
                o_mem_addr <= issue_we ? rec_addr : play_addr;
            end

            // Slow play: each tick steps the repeat index; the address moves on wrap.
            if (tick_slot && state == ST_PLAY && slow_active) begin
                if (phase_last) begin
                    phase     <= '0;
                    play_addr <= slow_sum[ADDR_W-1:0];
                end else begin
                    phase <= phase + 3'd1;
                end
            end

            if (fresh_rec) begin
                rec_addr <= '0;
                rec_len  <= '0;
                phase    <= '0;
            end
            if (play_zero || enter_stop) begin
                play_addr <= '0;
                phase     <= '0;
            end
        end
    end

    assign o_rec_len      = rec_len;
    assign o_interp_phase = phase;

endmodule

// File: tb/tb_rec_play_sequencer.sv
// Scoreboard bench for rec_play_sequencer: expected SRAM requests are queued by the
// stimulus and popped by a monitor on every accepted request.
module tb_rec_play_sequencer;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ev_valid = 1'b0;
    logic [3:0]    ev_code = '0;
    logic [1:0]    ev_mode = '0;
    logic [3:0]    ev_speed = '0;
    logic          tick = 1'b0;
    logic          ready = 1'b1;

    logic          req, we, ovr;
    logic [AW-1:0] addr;
    logic [2:0]    st, ph;
    logic [AW:0]   rlen;
    logic          req7, we7, ovr7;
    logic [AW-1:0] addr7;
    logic [2:0]    st7, ph7;
    logic [AW:0]   rlen7;

    int            errors = 0;
    int            checks = 0;
    logic [AW:0]   q[$];
    logic [AW:0]   q7[$];
    bit            mon_en = 1'b1;
    bit            mon7_en = 1'b0;

    rec_play_sequencer #(.ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_event_valid(ev_valid), .i_event_code(ev_code),
        .i_mode(ev_mode), .i_speed(ev_speed), .i_sample_tick(tick), .i_mem_ready(ready),
        .o_mem_req(req), .o_mem_we(we), .o_mem_addr(addr), .o_state(st),
        .o_rec_len(rlen), .o_interp_phase(ph), .o_overrun(ovr)
    );

    rec_play_sequencer #(.ADDR_W(AW), .MAX_ADDR(20'd7)) dut7 (
        .i_clk(clk), .i_rst(rst), .i_event_valid(ev_valid), .i_event_code(ev_code),
        .i_mode(ev_mode), .i_speed(ev_speed), .i_sample_tick(tick), .i_mem_ready(ready),
        .o_mem_req(req7), .o_mem_we(we7), .o_mem_addr(addr7), .o_state(st7),
        .o_rec_len(rlen7), .o_interp_phase(ph7), .o_overrun(ovr7)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [AW:0] e;
        if (mon_en && req && ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_req: unexpected request we=%0d addr=%0h", we, addr);
            end else begin
                e = q.pop_front();
                chk("main_we", 32'(we), 32'(e[AW]));
                chk("main_addr", 32'(addr), 32'(e[AW-1:0]));
            end
        end
        if (mon7_en && req7 && ready) begin
            if (q7.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL max_req: unexpected request we=%0d addr=%0h", we7, addr7);
            end else begin
                e = q7.pop_front();
                chk("max_we", 32'(we7), 32'(e[AW]));
                chk("max_addr", 32'(addr7), 32'(e[AW-1:0]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ev(input logic [3:0] code, input logic [1:0] mode, input logic [3:0] spd);
        ev_code  = code;
        ev_mode  = mode;
        ev_speed = spd;
        ev_valid = 1'b1;
        cyc(1);
        ev_valid = 1'b0;
        cyc(1);
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(3);
    endtask

    task automatic tick_exp(input logic w, input logic [AW-1:0] a);
        q.push_back({w, a});
        tick_pulse();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_len", 32'(rlen), 32'd0);
        chk("rst_phase", 32'(ph), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);

        // record five samples, then play them back
        ev(4'd1, 2'd0, 4'd0);
        chk("rec_state", 32'(st), 32'd1);
        for (int i = 0; i < 5; i++) tick_exp(1'b1, AW'(i));
        chk("rec_len5", 32'(rlen), 32'd5);
        ev(4'd3, 2'd0, 4'd0);
        chk("stop_state", 32'(st), 32'd3);
        ev(4'd4, 2'd0, 4'd0);
        chk("play_state", 32'(st), 32'd4);
        for (int i = 0; i < 4; i++) tick_exp(1'b0, AW'(i));
        chk("play_running", 32'(st), 32'd4);
        tick_exp(1'b0, AW'(4));
        chk("play_end_stop", 32'(st), 32'd3);
        tick_pulse();
        chk("stop_keeps_len", 32'(rlen), 32'd5);

        // fast playback, S=3
        ev(4'd1, 2'd0, 4'd0);
        for (int i = 0; i < 10; i++) tick_exp(1'b1, AW'(i));
        chk("rec_len10", 32'(rlen), 32'd10);
        ev(4'd3, 2'd0, 4'd0);
        ev(4'd4, 2'd2, 4'd3);
        tick_exp(1'b0, AW'(0));
        tick_exp(1'b0, AW'(3));
        tick_exp(1'b0, AW'(6));
        chk("fast_before_end", 32'(st), 32'd4);
        tick_exp(1'b0, AW'(9));
        chk("fast_end_stop", 32'(st), 32'd3);

        // slow playback, S=4
        ev(4'd4, 2'd1, 4'd4);
        tick_exp(1'b0, AW'(0));
        chk("slow_ph1", 32'(ph), 32'd1);
        tick_pulse();
        chk("slow_ph2", 32'(ph), 32'd2);
        tick_pulse();
        chk("slow_ph3", 32'(ph), 32'd3);
        tick_pulse();
        chk("slow_ph0", 32'(ph), 32'd0);
        tick_exp(1'b0, AW'(1));
        chk("slow_ph1b", 32'(ph), 32'd1);
        ev(4'd3, 2'd0, 4'd0);
        chk("slow_stop_phase", 32'(ph), 32'd0);

        // stalled handshake with an overrun tick and a PAUSE while pending
        ev(4'd4, 2'd0, 4'd0);
        ready = 1'b0;
        q.push_back({1'b0, AW'(0)});
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        chk("stall_req", 32'(req), 32'd1);
        chk("stall_addr", 32'(addr), 32'd0);
        chk("stall_we", 32'(we), 32'd0);
        cyc(1);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        chk("ovr_pulse", 32'(ovr), 32'd1);
        chk("stall_req2", 32'(req), 32'd1);
        ev_code = 4'd2; ev_mode = 2'd0; ev_speed = 4'd0;
        ev_valid = 1'b1;
        cyc(1);
        ev_valid = 1'b0;
        chk("ovr_once", 32'(ovr), 32'd0);
        chk("stall_addr2", 32'(addr), 32'd0);
        chk("pause_held", 32'(st), 32'd4);
        ready = 1'b1;
        cyc(1);
        chk("acc_req_drop", 32'(req), 32'd0);
        chk("pause_not_yet", 32'(st), 32'd4);
        cyc(1);
        chk("pause_applied", 32'(st), 32'd2);
        ev(4'd4, 2'd0, 4'd0);
        chk("resume_play", 32'(st), 32'd4);
        tick_exp(1'b0, AW'(1));

        // pause/resume during recording
        ev(4'd3, 2'd0, 4'd0);
        ev(4'd1, 2'd0, 4'd0);
        for (int i = 0; i < 3; i++) tick_exp(1'b1, AW'(i));
        ev(4'd2, 2'd0, 4'd0);
        chk("rec_paused", 32'(st), 32'd2);
        tick_pulse();
        tick_pulse();
        chk("paused_len", 32'(rlen), 32'd3);
        ev(4'd1, 2'd0, 4'd0);
        chk("rec_resumed", 32'(st), 32'd1);
        tick_exp(1'b1, AW'(3));
        chk("resumed_len", 32'(rlen), 32'd4);

        // PLAY from IDLE with an empty recording
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("idle_after_rst", 32'(st), 32'd0);
        ev(4'd4, 2'd0, 4'd0);
        chk("idle_play_ignored", 32'(st), 32'd0);
        tick_pulse();
        chk("main_queue_empty", 32'(q.size()), 32'd0);

        // memory-end auto-stop on the MAX_ADDR=7 instance
        mon_en  = 1'b0;
        mon7_en = 1'b1;
        ev(4'd1, 2'd0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) q7.push_back({1'b1, AW'(i)});
            tick_pulse();
        end
        chk("max_stop", 32'(st7), 32'd3);
        chk("max_len", 32'(rlen7), 32'd8);

        // asynchronous reset in the middle of a stalled write
        ev(4'd1, 2'd0, 4'd0);
        q7.push_back({1'b1, AW'(0)});
        tick_pulse();
        q7.push_back({1'b1, AW'(1)});
        tick_pulse();
        ready = 1'b0;
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        chk("mid_req", 32'(req7), 32'd1);
        chk("mid_addr", 32'(addr7), 32'd2);
        chk("mid_len", 32'(rlen7), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_req", 32'(req7), 32'd0);
        chk("async_we", 32'(we7), 32'd0);
        chk("async_addr", 32'(addr7), 32'd0);
        chk("async_state", 32'(st7), 32'd0);
        chk("async_len", 32'(rlen7), 32'd0);
        chk("async_phase", 32'(ph7), 32'd0);
        cyc(1);
        rst = 1'b0;
        ready = 1'b1;
        cyc(2);
        chk("max_queue_empty", 32'(q7.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rec_play_sequencer.md
Name: rec_play_sequencer

Overview:
- Sequences the recorder's SRAM sample stream.
- Decodes user control events (record/pause/stop/play plus speed mode) into a state machine.
- Generates one SRAM write (record) or read (play) request per audio sample tick, with a req/ready handshake.
- Applies fast (address skip) and slow (sample repeat with interpolation phase) playback; tracks recording length and auto-stops at memory end or recording end.
- Sits between the key/event decoder and the SRAM/codec datapath, alongside the LCD time core.

Parameters:
- ADDR_W, 20, SRAM word address width.
- MAX_ADDR, 20'hFFFFF, last writable address; recording auto-stops after writing it.

Ports:
- i_clk  input  1  system clock (50 MHz).
- i_rst  input  1  asynchronous, active-high reset.
- i_event_valid  input  1  one-cycle strobe qualifying i_event_code/i_mode/i_speed.
- i_event_code  input  4  1=RECORD, 2=PAUSE, 3=STOP, 4=PLAY, others ignored.
- i_mode  input  2  00 normal, 01 slow, 10 fast, 11 treated as normal.
- i_speed  input  4  speed factor 2..8; other values treated as 1.
- i_sample_tick  input  1  one-cycle pulse per audio sample (codec LRCK edge).
- i_mem_ready  input  1  SRAM accepts current request this cycle.
- o_mem_req  output  1  request pending.
- o_mem_we  output  1  1=write (record), 0=read (play); valid while o_mem_req.
- o_mem_addr  output  ADDR_W  request address.
- o_state  output  3  0 IDLE, 1 RECORD, 2 PAUSE, 3 STOP, 4 PLAY.
- o_rec_len  output  ADDR_W+1  samples in the stored recording.
- o_interp_phase  output  3  slow mode: repeat index 0..speed-1 of current sample; 0 otherwise.
- o_overrun  output  1  one-cycle pulse when a tick is dropped.

Behaviour:
- Reset values: state IDLE, all addresses 0, o_rec_len 0, o_mem_req 0, o_mem_we 0, o_interp_phase 0, o_overrun 0; the paused-from flag clears.
- Mode and speed latch on any valid event and apply from the next tick. The effective factor S is i_speed when mode is slow or fast and i_speed is in 2..8; otherwise S=1.
- Handshake:
  - o_mem_req rises the cycle after a qualifying tick.
  - o_mem_req, o_mem_addr and o_mem_we stay stable until the cycle i_mem_ready=1, then drop the next cycle.
  - Address update happens on the accept cycle.
- Tick while req pending: tick dropped, o_overrun pulses, no address change.
- Event while req pending: latched (one deep; a newer event overwrites it) and applied the cycle after accept.
- Events are otherwise applied the cycle after i_event_valid.
- RECORD state: each tick writes at rec_addr; on accept, rec_addr+1 and o_rec_len=rec_addr+1. After accepting the write at MAX_ADDR, go to STOP.
- PLAY state, normal/fast: each tick reads play_addr; on accept, play_addr+=S. If the new value is >= o_rec_len, go to STOP.
- PLAY state, slow: a read is issued only on ticks with phase 0.
  - Every tick advances o_interp_phase, wrapping at S-1.
  - On wrap, play_addr+1, with the same end check.
- Transitions (any event not listed is ignored):
  - IDLE: RECORD goes to RECORD with rec_addr=0, o_rec_len=0.
  - RECORD: PAUSE goes to PAUSE (from=REC); STOP goes to STOP.
  - PLAY: PAUSE goes to PAUSE (from=PLAY); STOP goes to STOP; RECORD goes to RECORD with a fresh recording (rec_addr=0, o_rec_len=0).
  - PAUSE: an event matching "from" resumes at the frozen address and phase. A RECORD event with from=PLAY starts a fresh recording. A PLAY event with from=REC goes to PLAY at play_addr 0. STOP goes to STOP.
  - STOP: RECORD starts a fresh recording; PLAY goes to PLAY at 0 only if o_rec_len≠0.
- Entering STOP: play_addr=0, o_interp_phase=0; o_rec_len is kept.
- PAUSE, STOP, IDLE: no new requests. A request already pending completes normally.
- Reset mid-request: o_mem_req drops immediately (async).

Test Plan:
- Record 5 ticks, ready=1 each → writes at addr 0..4, o_rec_len=5. Then STOP, PLAY, 6 ticks → reads 0..4, then state=STOP and play_addr=0.
- Fast S=3, o_rec_len=10, PLAY → reads at 0,3,6,9, then STOP after the 4th accept.
- Slow S=4 → one read per 4 ticks, o_interp_phase 0,1,2,3,0. Address advances 0→1 on the 4th tick.
- Hold ready=0 for 3 cycles with a tick in between → req, addr and we stable; o_overrun pulses once; address increments once on accept. A PAUSE event during the wait takes effect after accept.
- Pause/resume: record 3, PAUSE, 2 ticks (no reqs), RECORD → next write at addr 3. PLAY from IDLE with o_rec_len=0 → stays IDLE.
- MAX_ADDR=7 override: record 10 ticks → writes 0..7, state=STOP, o_rec_len=8. Assert i_rst mid-request → all outputs return to reset values without waiting for a clock edge.
